// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the fetch FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'd0;
    localparam logic [3:0] I_NOP   = 4'd1;
    localparam logic [3:0] I_CMOV  = 4'd2;
    localparam logic [3:0] I_IRMOV = 4'd3;
    localparam logic [3:0] I_RMMOV = 4'd4;
    localparam logic [3:0] I_MRMOV = 4'd5;
    localparam logic [3:0] I_OPQ   = 4'd6;
    localparam logic [3:0] I_JXX   = 4'd7;
    localparam logic [3:0] I_CALL  = 4'd8;
    localparam logic [3:0] I_RET   = 4'd9;
    localparam logic [3:0] I_PUSH  = 4'd10;
    localparam logic [3:0] I_POP   = 4'd11;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        HALT     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_predict_unit_ras_stack.sv
// Return-address stack: circular buffer with a top pointer; a push when full
// overwrites the oldest entry and the count saturates at RAS_DEPTH.
module ras_stack #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    // Flush only empties the count; stale entries are never read while empty.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push) begin
            ptr_d   = ptr_q + PTR_ONE;
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
        end else if (pop) begin
            ptr_d   = ptr_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end else begin
            ptr_d   = ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_q[ptr_d] <= push_data;
        end
    end

    assign top   = mem_q[ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with next-PC prediction (taken jxx/call, RAS for ret)
// and a small RUN/RET_WAIT/HALT fetch FSM.
module pc_predict_unit
    import y86_pkg::*;
#(
    parameter int               ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [3:0]                  f_icode,
    input  logic [ADDR_W-1:0]           f_valc,
    input  logic [ADDR_W-1:0]           f_valp,
    input  logic                        f_valid,
    input  logic                        stall,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [ADDR_W-1:0]           pc,
    output logic                        fetch_en,
    output logic                        halted,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ras_push_s, ras_pop_s, ras_flush_s;
    logic [ADDR_W-1:0] ras_top_s;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .flush     (ras_flush_s),
        .push_data (f_valp),
        .top       (ras_top_s),
        .count     (ras_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Redirect beats stall; stall freezes everything; otherwise predict.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ras_push_s  = 1'b0;
        ras_pop_s   = 1'b0;
        ras_flush_s = 1'b0;
        if (redirect_valid) begin
            state_d     = RUN;
            pc_d        = redirect_pc;
            ras_flush_s = 1'b1;
        end else if (stall) begin
            state_d = state_q;
        end else if (state_q == RUN && f_valid) begin
            case (f_icode)
                I_HALT: state_d = HALT;
                I_JXX:  pc_d = f_valc;
                I_CALL: begin
                    pc_d       = f_valc;
                    ras_push_s = 1'b1;
                end
                I_RET: begin
                    if (ras_count != '0) begin
                        pc_d      = ras_top_s;
                        ras_pop_s = 1'b1;
                    end else begin
                        state_d = RET_WAIT;
                    end
                end
                I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OPQ, I_PUSH, I_POP:
                    pc_d = f_valp;
                default: state_d = HALT;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    always_comb begin
        halted   = (state_q == HALT);
        if (reset || stall) begin
            fetch_en = 1'b0;
        end else begin
            fetch_en = (state_q == RUN);
        end
    end

    assign pc = pc_q;

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Parametrised successor to the SEQ PC-update logic, for the pipelined Y86-64 core.
- Holds the fetch PC in a register and predicts the next PC each cycle:
  - jxx and call predict taken (valC).
  - ret predicts from an internal return-address stack (RAS).
  - All other instructions use valP.
- Accepts a single generic redirect from the back end (jxx mispredict or ret correction) and a stall from the hazard unit.
- Runs a small fetch FSM for halt and empty-RAS ret.

Parameters:
- ADDR_W, 64, width of PC, valC, valP and redirect target.
- RESET_PC, 0, fetch address loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- f_icode  in  4  icode of the instruction currently at pc.
- f_valc  in  ADDR_W  decoded valC of that instruction.
- f_valp  in  ADDR_W  fall-through address of that instruction.
- f_valid  in  1  fetch data for pc is valid this cycle.
- stall  in  1  hold pc (F-stage stall).
- redirect_valid  in  1  back end demands a new fetch address.
- redirect_pc  in  ADDR_W  corrected target.
- pc  out  ADDR_W  current fetch address (registered).
- fetch_en  out  1  high when in RUN and not stalled.
- halted  out  1  FSM in HALT.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (synchronous): pc=RESET_PC, FSM=RUN, ras_count=0, halted=0, fetch_en=0 in the reset cycle and 1 in the first cycle after.
- All pc changes appear one cycle after the causing inputs; no combinational path from inputs to pc.
- Priority per cycle: reset > redirect_valid > stall > FSM/prediction.
- redirect_valid (any state):
  - pc<=redirect_pc, FSM<=RUN.
  - RAS flushed (ras_count<=0).
  - Takes effect even if stall is high.
- stall=1 without redirect: pc, FSM and RAS unchanged; fetch_en=0.
- FSM RUN, f_valid=1, no stall, per f_icode:
  - 0 (halt): pc holds, FSM<=HALT.
  - 7 (jxx): pc<=f_valc (predict taken).
  - 8 (call): pc<=f_valc; push f_valp.
  - 9 (ret), ras_count>0: pc<=top of stack; pop.
  - 9 (ret), ras_count==0: pc holds, FSM<=RET_WAIT.
  - 1-6, 10, 11: pc<=f_valp.
  - 12-15 (invalid): pc holds, FSM<=HALT.
- RUN with f_valid=0: pc holds, no RAS change.
- RET_WAIT: fetch_en=0, pc holds; leaves only on redirect or reset.
- HALT: halted=1, fetch_en=0, pc holds; leaves only on redirect (wrong-path halt) or reset.
- RAS:
  - Circular buffer with top pointer.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - Pop when empty never occurs (routed to RET_WAIT).
  - No simultaneous push and pop (one instruction per cycle).
- All address arithmetic is ADDR_W bits; no wrap detection (wrap is modulo 2^ADDR_W).

Decomposition:
- Shared package (y86_pkg):
  - icode constants: I_HALT=0, I_NOP=1, I_CMOV=2, I_IRMOV=3, I_RMMOV=4, I_MRMOV=5, I_OPQ=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSH=10, I_POP=11.
  - FSM state enum {RUN, RET_WAIT, HALT}.
- One sub-module: ras_stack (parametrised by ADDR_W, RAS_DEPTH)
  - Inputs: push, pop, flush, push_data.
  - Outputs: top, count.
  - Reset clears count only.

Test Plan:
- Reset with RESET_PC=0x100, then nop (valP=0x101) -> pc=0x100 during reset; pc=0x101 one cycle after the nop is fetched.
- call at 0x10 (valC=0x80, valP=0x19), then ret at 0x80 -> pc=0x80, ras_count=1, then pc=0x19, ras_count=0.
- Five consecutive calls with RAS_DEPTH=4 (valP=0xA,0xB,0xC,0xD,0xE), then four rets -> ras_count saturates at 4; rets return 0xE,0xD,0xC,0xB; a fifth ret enters RET_WAIT with fetch_en=0.
- jxx at 0x20 (valC=0x40) -> pc=0x40; redirect_valid with redirect_pc=0x29 two cycles later -> pc=0x29 next cycle, ras_count=0.
- halt fetched at 0x30 -> halted=1, pc stays 0x30; later redirect to 0x50 -> halted=0, pc=0x50, FSM=RUN.
- stall=1 held 3 cycles during a call fetch, then redirect during stall -> pc unchanged and no push while stalled; redirect target loaded the cycle after redirect_valid despite stall=1.
